// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Handles load-use bubbles, taken-branch squashes, multi-cycle multiply
// sequencing and data-memory wait freezes.
// Optional macro HAZ_PERF_CNT_EN adds a 32-bit count of PC-stall cycles on
// stall_cycles; without it the port is tied to zero.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mul,
  input  logic        branch_taken,
  input  logic        mem_wait,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        exmem_flush,
  output logic        mul_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MUL_REL  = 2'd2
  } state_t;

  localparam bit MUL_MULTI = (MUL_LAT > 1);
  localparam bit MUL_LONG  = (MUL_LAT > 2);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load_use;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // State and multiply countdown register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and stall/flush decode; mem_wait freezes everything first.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    exmem_flush = 1'b0;
    mul_busy    = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        mul_busy    = (state == MUL_WAIT);
      end else begin
        unique case (state)
          RUN: begin
            if (branch_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (ex_mul && MUL_MULTI) begin
              pc_stall    = 1'b1;
              ifid_stall  = 1'b1;
              idex_stall  = 1'b1;
              exmem_flush = 1'b1;
              mul_busy    = 1'b1;
              cnt_next    = CNT_INIT;
              state_next  = MUL_LONG ? MUL_WAIT : MUL_REL;
            end else if (load_use) begin
              pc_stall   = 1'b1;
              ifid_stall = 1'b1;
              idex_flush = 1'b1;
            end
          end
          MUL_WAIT: begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
            mul_busy    = 1'b1;
            if (cnt == CNT_W'(1)) begin
              state_next = MUL_REL;
            end else begin
              cnt_next = cnt - CNT_W'(1);
            end
          end
          MUL_REL: begin
            if (branch_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end
            state_next = RUN;
          end
          default: begin
            state_next = RUN;
          end
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Count every cycle the PC is held; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (pc_stall) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mul, branch_taken, mem_wait;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic        exmem_stall, exmem_flush, mul_busy;
  logic [31:0] stall_cycles;

  pipe_hazard_ctrl #(.MUL_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mul(ex_mul),
    .branch_taken(branch_taken), .mem_wait(mem_wait),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .exmem_flush(exmem_flush),
    .mul_busy(mul_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: stall cycles still owed by the current multiply, pending release
  // cycle, and expected performance count.
  int          sl;
  bit          rel;
  logic [31:0] perf;

  // Bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush
  //            exmem_stall exmem_flush mul_busy
  localparam logic [7:0] O_NONE   = 8'b0000_0000;
  localparam logic [7:0] O_LU     = 8'b1100_1000;
  localparam logic [7:0] O_BR     = 8'b0010_1000;
  localparam logic [7:0] O_MUL    = 8'b1101_0011;
  localparam logic [7:0] O_MW     = 8'b1101_0100;
  localparam logic [7:0] O_MW_MUL = 8'b1101_0101;

  function automatic logic [7:0] outv();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
            exmem_stall, exmem_flush, mul_busy};
  endfunction

  function automatic logic [31:0] perf_exp();
`ifdef HAZ_PERF_CNT_EN
    return perf;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Called at posedge+1: drive one cycle of inputs, compare, advance a clock.
  task automatic step(input logic mw, input logic br, input logic mul,
                      input logic mr, input logic u1, input logic u2,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      output logic [7:0] got);
    logic [7:0] exp;
    int         sl_n;
    bit         rel_n;
    bit         lu;
    mem_wait = mw; branch_taken = br; ex_mul = mul; ex_mem_read = mr;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rs1 = r1; id_rs2 = r2; ex_rd = rd;
    #1;
    lu    = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
    exp   = O_NONE;
    sl_n  = sl;
    rel_n = rel;
    if (mw) begin
      exp = (sl > 0) ? O_MW_MUL : O_MW;
    end else if (sl > 0) begin
      exp  = O_MUL;
      sl_n = sl - 1;
      if (sl_n == 0) rel_n = 1;
    end else if (rel) begin
      exp   = br ? O_BR : O_NONE;
      rel_n = 0;
    end else if (br) begin
      exp = O_BR;
    end else if (mul && LAT > 1) begin
      exp  = O_MUL;
      sl_n = LAT - 2;
      if (sl_n == 0) rel_n = 1;
    end else if (lu) begin
      exp = O_LU;
    end
    got = outv();
    chk("outs", got, {24'd0, exp});
    chk("stall_cycles", stall_cycles, perf_exp());
    @(posedge clk);
    #1;
    sl  = sl_n;
    rel = rel_n;
    if (exp[7]) perf = perf + 32'd1;
  endtask

  logic [7:0] g;

  initial begin
    sl = 0; rel = 0; perf = '0;
    rst = 1'b1;
    mem_wait = 1'b1; branch_taken = 1'b1; ex_mul = 1'b1; ex_mem_read = 1'b1;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd3; ex_rd = 5'd3;
    @(posedge clk); #1;
    chk("reset_outs", {24'd0, outv()}, 32'd0);
    chk("reset_perf", stall_cycles, 32'd0);
    rst = 1'b0;

    // Load-use bubble, then clean cycle.
    step(0, 0, 0, 1, 0, 1, 5'd0, 5'd5, 5'd5, g); chk("lu_bubble", {24'd0, g}, {24'd0, O_LU});
    step(0, 0, 0, 0, 0, 1, 5'd0, 5'd5, 5'd5, g); chk("lu_after", {24'd0, g}, 32'd0);

    // Multiply with ex_mul held: 3 stall cycles, release, back to RUN.
    step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mul_t0", {24'd0, g}, {24'd0, O_MUL});
    step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mul_t1", {24'd0, g}, {24'd0, O_MUL});
    step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mul_t2", {24'd0, g}, {24'd0, O_MUL});
    step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mul_rel", {24'd0, g}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mul_run", {24'd0, g}, 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_after_lu_mul", stall_cycles, 32'd4);
`else
    chk("perf_after_lu_mul", stall_cycles, 32'd0);
`endif

    // Load to x0 never stalls.
    step(0, 0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd0, g); chk("lu_x0", {24'd0, g}, 32'd0);

    // Branch overrides load-use.
    step(0, 1, 0, 1, 1, 0, 5'd7, 5'd0, 5'd7, g); chk("br_over_lu", {24'd0, g}, {24'd0, O_BR});

    // mem_wait during a multiply stretches the window.
    step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mw_t0", {24'd0, g}, {24'd0, O_MUL});
    step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mw_t1", {24'd0, g}, {24'd0, O_MW_MUL});
    step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mw_t2", {24'd0, g}, {24'd0, O_MW_MUL});
    step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mw_t3", {24'd0, g}, {24'd0, O_MUL});
    step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mw_t4", {24'd0, g}, {24'd0, O_MUL});
    step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mw_rel", {24'd0, g}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("mw_run", {24'd0, g}, 32'd0);

    // Asynchronous reset in MUL_WAIT.
    step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("ar_t0", {24'd0, g}, {24'd0, O_MUL});
    ex_mul = 1'b0;
    #1;
    chk("ar_wait_busy", {31'd0, mul_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_outs", {24'd0, outv()}, 32'd0);
    sl = 0; rel = 0; perf = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ar_perf", stall_cycles, 32'd0);
    step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("ar_run0", {24'd0, g}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, g); chk("ar_run1", {24'd0, g}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Watches the ID and EX stages, the multi-cycle multiplier and the data-memory ready signal.
- Drives the stall and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Sequences multi-cycle multiply with a small FSM; inserts load-use bubbles and squashes wrong-path instructions on taken jumps/branches.

Parameters:
- MUL_LAT, 4, total EX-stage cycles a multiply occupies; legal range 1..16.
- CNT_W, 4, width of the internal multiply cycle counter; must hold MUL_LAT-1.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_rs1  in  5  rs1 address of instruction in ID
- id_rs2  in  5  rs2 address of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_mul  in  1  EX instruction uses multiplier (AluMulSel of ID/EX output)
- branch_taken  in  1  EX resolved taken branch/jump (redirect this cycle)
- mem_wait  in  1  data memory not ready; whole pipe must freeze
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  zero IF/ID register
- idex_stall  out  1  hold ID/EX register
- idex_flush  out  1  zero ID/EX register (bubble)
- exmem_stall  out  1  hold EX/MEM register
- exmem_flush  out  1  zero EX/MEM register (bubble)
- mul_busy  out  1  FSM in MUL_WAIT
- stall_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Outputs are combinational from state and inputs. While rst=1: state=RUN, cnt=0, all outputs 0.
- Only one of stall/flush per register is ever asserted; flush has priority over stall except under mem_wait.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority 1, mem_wait=1 in any state:
  - pc_stall, ifid_stall, idex_stall, exmem_stall = 1; all flushes = 0.
  - FSM state and cnt frozen.
  - branch_taken, load_use and ex_mul ignored that cycle.
- State RUN, priority 2, branch_taken=1: ifid_flush=1, idex_flush=1, no stalls. Overrides load_use.
- State RUN, priority 3, ex_mul=1 and MUL_LAT>1:
  - pc_stall, ifid_stall, idex_stall = 1; exmem_flush=1.
  - cnt <= MUL_LAT-2.
  - next state MUL_WAIT if MUL_LAT>2, else MUL_REL.
- State RUN, priority 4, load_use=1: pc_stall=1, ifid_stall=1, idex_flush=1. Exactly one bubble; stay in RUN.
- State RUN, otherwise: all outputs 0.
- ex_mul with MUL_LAT=1: no stall; multiply completes in one cycle.
- MUL_WAIT:
  - pc_stall, ifid_stall, idex_stall, exmem_flush = 1.
  - If cnt==1, next state MUL_REL; else cnt decrements.
  - branch_taken and load_use ignored; the multiply occupies EX.
- MUL_REL:
  - Multiply result advances into EX/MEM. All outputs 0 except a branch_taken flush (not expected).
  - ex_mul ignored this cycle so the same instruction does not retrigger.
  - Next state RUN. load_use is not evaluated (EX holds a mul, not a load).
- Total stall window for one multiply: exactly MUL_LAT-1 cycles, not counting mem_wait cycles.
- Back-to-back multiplies: the second enters EX after MUL_REL and is seen in RUN, so it gets its own full window.
- rst asserted mid-multiply: returns immediately to RUN with all outputs 0. The pipeline registers are also reset, so no partial multiply survives.
- mul_busy = (state==MUL_WAIT) or (state==RUN & ex_mul & MUL_LAT>1 & !mem_wait & !branch_taken).

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles is a 32-bit register, reset 0.
  - Increments by 1 each cycle pc_stall=1. Wraps 0xFFFFFFFF -> 0.
  - Frozen under reset only.
- Undefined: stall_cycles tied to 0; no counter flops.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID reads rs2=5, id_uses_rs2=1 -> one cycle of pc_stall=1, ifid_stall=1, idex_flush=1; next cycle (ex_mem_read=0) all 0. Same with ex_rd=0 -> no stall.
- MUL_LAT=4, ex_mul held 1 from cycle T -> stalls + exmem_flush asserted T..T+2 (3 cycles); T+3 all 0 (MUL_REL) even though ex_mul=1; T+4 back in RUN.
- branch_taken=1 with load_use=1 simultaneously -> ifid_flush=1, idex_flush=1, pc_stall=0.
- mem_wait=1 for 2 cycles inserted at T+1 of a MUL_LAT=4 multiply -> all four stalls=1 and no flush during those cycles; multiply window extends to end at T+4; MUL_REL at T+5.
- rst pulsed asynchronously (mid-cycle) while in MUL_WAIT -> outputs 0 immediately; after release with ex_mul=0 the controller stays in RUN.
- With HAZ_PERF_CNT_EN: the first and second tests run back-to-back -> stall_cycles=4; without the macro, stall_cycles=0 throughout.
